bcd_sseg_scanner: RTL and testbench
===================================

# bcd_sseg_scanner

Parametrised multiplexed seven-segment display driver for the ROM chip reader front panel. It accepts a binary value of configurable width and converts it to packed BCD with a sequential, one-bit-per-cycle double-dabble engine. It then time-multiplexes a configurable number of digits onto one shared segment bus. It replaces the fixed 9-bit / 3-digit address display and adds a load/busy handshake, decimal-point control, a programmable scan rate and atomic display update.

## Interface
Parameters:
- BIN_WIDTH, 16, width of binary input; range 4..32
- DIGITS, 5, number of digits driven; must satisfy 10^DIGITS > 2^BIN_WIDTH, otherwise elaboration fails via `$error`
- SCAN_DIVIDER, 1024, clk cycles per digit dwell; must be >= 2

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- value  in  BIN_WIDTH  binary value to display; sampled only on accepted load
- load  in  1  single-cycle request to convert `value`
- dp_mask  in  DIGITS  decimal point enable per digit; bit i controls digit i; sampled with value
- busy  out  1  high while a conversion is in progress
- sseg_indicator  out  8  registered segments {dp,a,b,c,d,e,f,g}, bit7=dp, bit6=a; active-high
- digits  out  DIGITS  registered one-hot digit select, active-high; bit 0 is the least significant digit

## Operation
- **FSM states:** IDLE, SHIFT, COMMIT.
- **IDLE:** load=1 captures value into the shift register and dp_mask into pending_dp, clears scratch BCD and the bit counter, then goes to SHIFT. load=0 stays in IDLE.
- **SHIFT:** each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by one. Runs exactly BIN_WIDTH cycles (counter 0..BIN_WIDTH-1), then goes to COMMIT.
- **COMMIT:** copies scratch BCD to display_bcd and pending_dp to display_dp in one cycle, then returns to IDLE. The displayed value never shows partial results.
- **Load while busy:** load in SHIFT or COMMIT is ignored (dropped, not queued).
- **Scan prescaler:** counts 0..SCAN_DIVIDER-1 continuously and is independent of the FSM.
- **Digit advance:** on terminal count, the digit index advances; DIGITS-1 wraps to 0.
- **Per-digit output:** digits and sseg_indicator are updated on the same edge from display_bcd nibble[index] and display_dp[index], so select and segments never mismatch.
- **Segment codes (a..g):**
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - Nibbles >9 are unreachable; they decode to 0000001 (dash).

## Timing
- **Reset values (asserted, async):**
  - FSM=IDLE, busy=0
  - digits = one-hot bit 0, sseg_indicator=8'h00
  - display_bcd=0, display_dp=0, prescaler=0, index=0
- **Conversion timing:** load sampled high at edge k (state IDLE):
  - busy=1 from edge k, so it is visible in cycle k+1.
  - SHIFT occupies edges k+1..k+BIN_WIDTH.
  - COMMIT occurs at edge k+BIN_WIDTH+1, where busy falls to 0.
  - Next load is accepted at edge k+BIN_WIDTH+2.
- **Conversion latency:** BIN_WIDTH+2 cycles from load to display_bcd valid.
- **Display latency:** a committed value appears on a digit at that digit's next scan slot, at most DIGITS*SCAN_DIVIDER cycles later.
- **Commit mid-dwell:** if COMMIT coincides with a digit's dwell, the segments change at the next prescaler terminal count, not mid-dwell.
- **Reset mid-conversion:** aborts the conversion; display returns to 0 with no commit.
- **Load and terminal count in the same cycle:** both take effect independently.

## Configuration
- Macro: `BCD_SSEG_SCANNER_LEADING_ZERO_BLANK_EN`.
- **Defined:** every digit above the most significant nonzero digit of display_bcd drives a=..g=0. Its dp bit still follows display_dp. Digit 0 is never blanked, so value 0 shows a single "0". Blanking is computed at COMMIT and stored as a DIGITS-bit mask.
- **Undefined:** all digits always show their BCD value, including leading zeros; no blank-mask logic is synthesised.

## Test plan
- **Reset:** assert reset for 3 cycles mid-scan -> digits=00001, sseg_indicator=8'h00, busy=0 immediately (async), with no clock edge needed.
- **Normal conversion:** defaults, SCAN_DIVIDER=4; load value=16'd12345, dp_mask=5'b00100 -> busy high for exactly 17 cycles. Digits 0..4 then show 5,4,3,2,1 (a..g 1011011, 0110011, 1111001, 1101101, 0110000), with dp=1 only on digit 2.
- **Maximum value:** load 16'hFFFF -> digits show 5,3,5,5,6 (65535). A second load asserted while busy is ignored, and the display stays 65535.
- **Leading-zero blanking:** load 16'd7. With the macro, digits 1..4 output 8'h00 and digit 0 shows 0_1110000. Without the macro, digits 1..4 show 0_1111110.
- **Scan wrap:** index goes 0,1,2,3,4,0 at exactly SCAN_DIVIDER-cycle intervals, and digits stays one-hot every cycle.
- **Reset mid-conversion:** load 16'd999, assert reset at SHIFT cycle 5 then release -> busy=0, display_bcd=0, and the next load of 16'd42 shows 2,4 after 18 cycles.

Source files
------------

// File: rtl/bcd_sseg_scanner.sv
// bcd_sseg_scanner: sequential double-dabble binary-to-BCD converter feeding a
// multiplexed seven-segment scanner. Option macro: BCD_SSEG_SCANNER_LEADING_ZERO_BLANK_EN.
`default_nettype none

module bcd_sseg_scanner #(
    parameter int BIN_WIDTH    = 16,
    parameter int DIGITS       = 5,
    parameter int SCAN_DIVIDER = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIN_WIDTH-1:0] value,
    input  logic                 load,
    input  logic [DIGITS-1:0]    dp_mask,
    output logic                 busy,
    output logic [7:0]           sseg_indicator,
    output logic [DIGITS-1:0]    digits
);

    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
    localparam int c_PRE_W = (SCAN_DIVIDER > 1) ? $clog2(SCAN_DIVIDER) : 1;
    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BIN_WIDTH - 1);
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(SCAN_DIVIDER - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DIGITS - 1);
    localparam longint unsigned c_POW2 = 64'd1 << BIN_WIDTH;

    function automatic bit f_digits_fit();
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < DIGITS; i++) begin
            if (p > c_POW2) return 1'b1;
            p = p * 64'd10;
        end
        return (p > c_POW2);
    endfunction

    generate
        if (BIN_WIDTH < 4 || BIN_WIDTH > 32) begin : g_bad_width
            $error("bcd_sseg_scanner: BIN_WIDTH must be 4..32");
        end
        if (!f_digits_fit()) begin : g_bad_digits
            $error("bcd_sseg_scanner: DIGITS too small for BIN_WIDTH");
        end
        if (SCAN_DIVIDER < 2) begin : g_bad_divider
            $error("bcd_sseg_scanner: SCAN_DIVIDER must be >= 2");
        end
    endgenerate

    function automatic logic [6:0] f_seg(input logic [3:0] n);
        case (n)
            4'd0:    f_seg = 7'b1111110;
            4'd1:    f_seg = 7'b0110000;
            4'd2:    f_seg = 7'b1101101;
            4'd3:    f_seg = 7'b1111001;
            4'd4:    f_seg = 7'b0110011;
            4'd5:    f_seg = 7'b1011011;
            4'd6:    f_seg = 7'b1011111;
            4'd7:    f_seg = 7'b1110000;
            4'd8:    f_seg = 7'b1111111;
            4'd9:    f_seg = 7'b1111011;
            default: f_seg = 7'b0000001;
        endcase
    endfunction

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [BIN_WIDTH-1:0]   r_bin;
    logic [c_BCD_W-1:0]     r_bcd;
    logic [c_BCD_W-1:0]     w_adj;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [DIGITS-1:0]      r_pend_dp;
    logic [c_BCD_W-1:0]     r_disp_bcd;
    logic [DIGITS-1:0]      r_disp_dp;
    logic                   r_busy;
    logic [c_PRE_W-1:0]     r_pre;
    logic [c_IDX_W-1:0]     r_idx;
    logic [c_IDX_W-1:0]     w_next_idx;
    logic [3:0]             w_sel_nib;
    logic                   w_sel_dp;
    logic                   w_sel_blank;
    logic [DIGITS-1:0]      r_digits;
    logic [7:0]             r_sseg;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (load) w_next_state = S_SHIFT;
            S_SHIFT:  if (r_cnt == c_CNT_LAST) w_next_state = S_COMMIT;
            S_COMMIT: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != S_IDLE);
        end
    end

    // Add-3 correction applied to every nibble before each shift.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
        end
    end

`ifdef BCD_SSEG_SCANNER_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] w_blank;
    logic [DIGITS-1:0] r_blank;

    // A digit blanks when it and every digit above it are zero; digit 0 never blanks.
    always_comb begin
        w_blank = '0;
        w_blank[DIGITS-1] = (r_bcd[c_BCD_W-4 +: 4] == 4'd0);
        for (int i = DIGITS - 2; i >= 1; i--) begin
            w_blank[i] = w_blank[i+1] && (r_bcd[i*4 +: 4] == 4'd0);
        end
        w_blank[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_blank <= '0;
        end else if (r_state == S_COMMIT) begin
            r_blank <= w_blank;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_pend_dp  <= '0;
            r_disp_bcd <= '0;
            r_disp_dp  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_bin     <= value;
                        r_bcd     <= '0;
                        r_cnt     <= '0;
                        r_pend_dp <= dp_mask;
                    end
                end
                S_SHIFT: begin
                    r_bcd <= {w_adj[c_BCD_W-2:0], r_bin[BIN_WIDTH-1]};
                    r_bin <= {r_bin[BIN_WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_COMMIT: begin
                    r_disp_bcd <= r_bcd;
                    r_disp_dp  <= r_pend_dp;
                end
                default: ;
            endcase
        end
    end

    assign w_next_idx = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;

    always_comb begin
        w_sel_nib   = 4'd0;
        w_sel_dp    = 1'b0;
        w_sel_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_next_idx == c_IDX_W'(i)) begin
                w_sel_nib = r_disp_bcd[i*4 +: 4];
                w_sel_dp  = r_disp_dp[i];
`ifdef BCD_SSEG_SCANNER_LEADING_ZERO_BLANK_EN
                w_sel_blank = r_blank[i];
`endif
            end
        end
    end

    // Select and segments load together at terminal count so they never disagree.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre    <= '0;
            r_idx    <= '0;
            r_digits <= DIGITS'(1);
            r_sseg   <= 8'h00;
        end else if (r_pre == c_PRE_LAST) begin
            r_pre    <= '0;
            r_idx    <= w_next_idx;
            r_digits <= DIGITS'(1) << w_next_idx;
            r_sseg   <= {w_sel_dp, (w_sel_blank ? 7'b0000000 : f_seg(w_sel_nib))};
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    assign busy           = r_busy;
    assign sseg_indicator = r_sseg;
    assign digits         = r_digits;

endmodule

`default_nettype wire

// File: tb/tb_bcd_sseg_scanner.sv
// Directed self-checking bench for bcd_sseg_scanner (16-bit, 5 digits, divider 4).
`default_nettype none

module tb_bcd_sseg_scanner;

    localparam int BW = 16;
    localparam int ND = 5;
    localparam int SD = 4;
`ifdef BCD_SSEG_SCANNER_LEADING_ZERO_BLANK_EN
    localparam logic [7:0] Z = 8'h00;
`else
    localparam logic [7:0] Z = 8'h7E;
`endif

    logic          clk     = 1'b0;
    logic          reset   = 1'b1;
    logic [BW-1:0] value   = '0;
    logic          load    = 1'b0;
    logic [ND-1:0] dp_mask = '0;
    logic          busy;
    logic [7:0]    sseg_indicator;
    logic [ND-1:0] digits;

    int n_checks = 0;
    int n_errors = 0;

    bcd_sseg_scanner #(
        .BIN_WIDTH   (BW),
        .DIGITS      (ND),
        .SCAN_DIVIDER(SD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .value         (value),
        .load          (load),
        .dp_mask       (dp_mask),
        .busy          (busy),
        .sseg_indicator(sseg_indicator),
        .digits        (digits)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [BW-1:0] v, input logic [ND-1:0] dp);
        value   = v;
        dp_mask = dp;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
    endtask

    task automatic measure_busy(input string tag);
        int cnt;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk(tag, cnt, BW + 1);
    endtask

    // exp packs {digit4, ..., digit0}; settles one full scan first.
    task automatic check_disp(input string tag, input logic [8*ND-1:0] exp);
        int t;
        wait_cycles(ND * SD + 2);
        for (int d = 0; d < ND; d++) begin
            t = 0;
            while (digits !== (ND'(1) << d) && t < 2 * ND * SD) begin
                @(negedge clk);
                t++;
            end
            chk($sformatf("%s sel%0d", tag, d), 32'(digits), 32'(ND'(1) << d));
            chk($sformatf("%s seg%0d", tag, d), 32'(sseg_indicator), 32'(exp[d*8 +: 8]));
        end
    endtask

    initial begin
        logic [ND-1:0] prev;
        logic [ND-1:0] exp_rot;
        int since;
        int nchg;

        #1 reset = 1'b0;
        wait_cycles(2);
        chk("por busy", 32'(busy), 0);
        chk("por digits", 32'(digits), 1);
        chk("por sseg", 32'(sseg_indicator), 0);
        reset = 1'b1;

        wait_cycles(7);
        reset = 1'b0;
        #1;
        chk("async busy", 32'(busy), 0);
        chk("async digits", 32'(digits), 1);
        chk("async sseg", 32'(sseg_indicator), 0);
        wait_cycles(3);
        reset = 1'b1;
        wait_cycles(2);

        do_load(16'd12345, 5'b00100);
        measure_busy("busy12345");
        check_disp("v12345", {8'h30, 8'h6D, 8'hF9, 8'h33, 8'h5B});

        do_load(16'hFFFF, 5'b00000);
        wait_cycles(2);
        value = 16'd1;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        begin
            int t;
            t = 0;
            while (busy === 1'b1 && t < 100) begin
                @(negedge clk);
                t++;
            end
        end
        wait_cycles(3);
        chk("dropped load busy", 32'(busy), 0);
        check_disp("v65535", {8'h5F, 8'h5B, 8'h5B, 8'h79, 8'h5B});

        do_load(16'd7, 5'b00000);
        measure_busy("busy7");
        check_disp("v7", {Z, Z, Z, Z, 8'h70});

        prev  = digits;
        since = 0;
        nchg  = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            since++;
            chk("onehot", 32'($onehot(digits)), 1);
            if (digits !== prev) begin
                exp_rot = (prev == ND'(1) << (ND - 1)) ? ND'(1) : prev << 1;
                chk("scan order", 32'(digits), 32'(exp_rot));
                if (nchg > 0) chk("scan interval", since, SD);
                nchg++;
                since = 0;
                prev  = digits;
            end
        end
        chk("scan count", 32'(nchg >= 12), 1);

        do_load(16'd999, 5'b00000);
        wait_cycles(4);
        reset = 1'b0;
        #1;
        chk("midconv busy", 32'(busy), 0);
        chk("midconv digits", 32'(digits), 1);
        chk("midconv sseg", 32'(sseg_indicator), 0);
        wait_cycles(3);
        reset = 1'b1;
        wait_cycles(2);
        chk("after abort busy", 32'(busy), 0);
        check_disp("v0", {Z, Z, Z, Z, 8'h7E});

        do_load(16'd42, 5'b00000);
        measure_busy("busy42");
        check_disp("v42", {Z, Z, Z, 8'h33, 8'h6D});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
